// File: rtl/verificar_senha.sv
// verificar_senha: checks submitted PINs against master/user PINs, counts failures, enforces timed lockout.
// pin_in = {status, d3, d2, d1, d0}; data_setup[84:0] = {master_pin, pin1, pin2, pin3, pin4}, upper bits unused.
`default_nettype none

module verificar_senha #(
  parameter int MAX_TENTATIVAS = 5,
  parameter int BLOQUEIO_SEG   = 30,
  parameter int TICKS_PER_SEC  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] pin_in,
  input  logic [99:0] data_setup,
  output logic        senha_ok,
  output logic        master_ok,
  output logic        senha_fail,
  output logic        bloqueado,
  output logic [3:0]  tentativas,
  output logic [6:0]  tempo_restante
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARA   = 2'd1,
    BLOQUEADO = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic            r_status_prev;
  logic [15:0]     r_pin, w_pin;
  logic            r_pend, w_pend;
  logic [TW-1:0]   r_tick, w_tick;
  logic            w_sok, w_mok, w_sfail, w_bloq;
  logic [3:0]      w_tent, w_tent_inc;
  logic [6:0]      w_tempo;
  logic            w_sub, w_blank, w_master_match, w_user_match;
  logic            w_unused_setup;

  function automatic logic f_match(input logic [16:0] stored, input logic [15:0] entered);
    return stored[16] && (stored[15:0] == entered);
  endfunction

  assign w_sub   = pin_in[16] && !r_status_prev;
  assign w_blank = (r_pin[15:12] == 4'hE) || (r_pin[11:8] == 4'hE) ||
                   (r_pin[7:4]   == 4'hE) || (r_pin[3:0]  == 4'hE);
  assign w_master_match = !w_blank && f_match(data_setup[84:68], r_pin);
  assign w_user_match   = !w_blank && (f_match(data_setup[67:51], r_pin) ||
                                       f_match(data_setup[50:34], r_pin) ||
                                       f_match(data_setup[33:17], r_pin) ||
                                       f_match(data_setup[16:0],  r_pin));
  assign w_tent_inc = (tentativas >= 4'(MAX_TENTATIVAS)) ? 4'(MAX_TENTATIVAS) : tentativas + 4'd1;
  assign w_unused_setup = ^data_setup[99:85];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_comb begin
    w_state = r_state;
    w_pin   = r_pin;
    w_pend  = 1'b0;
    w_tick  = r_tick;
    w_sok   = 1'b0;
    w_mok   = 1'b0;
    w_sfail = 1'b0;
    w_bloq  = bloqueado;
    w_tent  = tentativas;
    w_tempo = tempo_restante;
    case (r_state)
      IDLE: begin
        if (w_sub) begin
          w_pin   = pin_in[15:0];
          w_state = COMPARA;
        end
      end
      COMPARA: begin
        if (w_master_match) begin
          w_mok   = 1'b1;
          w_tent  = 4'd0;
          w_state = IDLE;
        end else if (w_user_match) begin
          w_sok   = 1'b1;
          w_tent  = 4'd0;
          w_state = IDLE;
        end else begin
          w_sfail = 1'b1;
          w_tent  = w_tent_inc;
          if (w_tent_inc == 4'(MAX_TENTATIVAS)) begin
            w_state = BLOQUEADO;
            w_bloq  = 1'b1;
            w_tempo = 7'(BLOQUEIO_SEG);
            w_tick  = '0;
          end else begin
            w_state = IDLE;
          end
        end
      end
      BLOQUEADO: begin
        // Only the master PIN can break a lockout; everything else just lets the countdown run.
        if (r_pend && w_master_match) begin
          w_mok   = 1'b1;
          w_bloq  = 1'b0;
          w_tempo = 7'd0;
          w_tent  = 4'd0;
          w_tick  = '0;
          w_state = IDLE;
        end else begin
          if (r_tick == TW'(TICKS_PER_SEC - 1)) begin
            w_tick = '0;
            if (tempo_restante <= 7'd1) begin
              w_tempo = 7'd0;
              w_bloq  = 1'b0;
              w_tent  = 4'd0;
              w_state = IDLE;
            end else begin
              w_tempo = tempo_restante - 7'd1;
            end
          end else begin
            w_tick = r_tick + TW'(1);
          end
          if (w_sub && (w_state == BLOQUEADO)) begin
            w_pin  = pin_in[15:0];
            w_pend = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status_prev  <= 1'b0;
      r_pin          <= '0;
      r_pend         <= 1'b0;
      r_tick         <= '0;
      senha_ok       <= 1'b0;
      master_ok      <= 1'b0;
      senha_fail     <= 1'b0;
      bloqueado      <= 1'b0;
      tentativas     <= 4'd0;
      tempo_restante <= 7'd0;
    end else begin
      r_status_prev  <= pin_in[16];
      r_pin          <= w_pin;
      r_pend         <= w_pend;
      r_tick         <= w_tick;
      senha_ok       <= w_sok;
      master_ok      <= w_mok;
      senha_fail     <= w_sfail;
      bloqueado      <= w_bloq;
      tentativas     <= w_tent;
      tempo_restante <= w_tempo;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_verificar_senha.sv
// Scoreboard bench for verificar_senha: stimulus queues expected pulses, a monitor pops and compares them.
`default_nettype none

module tb_verificar_senha;

  typedef struct packed {
    logic       sok;
    logic       mok;
    logic       sfail;
    logic [3:0] tent;
    logic       bloq;
    logic [6:0] tempo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] pin_in;
  logic [99:0] data_setup;
  logic        senha_ok, master_ok, senha_fail, bloqueado;
  logic [3:0]  tentativas;
  logic [6:0]  tempo_restante;

  logic [16:0] m_pin, p1, p2, p3, p4;
  assign data_setup = {15'd0, m_pin, p1, p2, p3, p4};

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  verificar_senha #(
    .MAX_TENTATIVAS(5),
    .BLOQUEIO_SEG  (3),
    .TICKS_PER_SEC (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pin_in        (pin_in),
    .data_setup    (data_setup),
    .senha_ok      (senha_ok),
    .master_ok     (master_ok),
    .senha_fail    (senha_fail),
    .bloqueado     (bloqueado),
    .tentativas    (tentativas),
    .tempo_restante(tempo_restante)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic exp_t snap();
    return '{senha_ok, master_ok, senha_fail, tentativas, bloqueado, tempo_restante};
  endfunction

  function automatic exp_t mk(input logic s, input logic m, input logic f,
                              input logic [3:0] t, input logic b, input logic [6:0] tr);
    return '{s, m, f, t, b, tr};
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (senha_ok || master_ok || senha_fail) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 32'(snap()), 32'd0);
      end else begin
        chk("pulse", 32'(snap()), 32'(q.pop_front()));
      end
    end
  end

  task automatic submit(input logic [15:0] d, input bit expect_p, input exp_t e);
    int iters;
    if (expect_p) q.push_back(e);
    @(posedge clk); #1 pin_in = {1'b1, d};
    @(posedge clk);
    @(posedge clk); #1 pin_in[16] = 1'b0;
    iters = 0;
    while (q.size() != 0 && iters < 6) begin
      @(negedge clk); #1;
      iters++;
    end
    if (q.size() != 0) begin
      chk("pulse_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end else if (expect_p) begin
      chk("pulse_latency", 32'(iters), 32'd1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'(snap()), 32'd0);
  endtask

  task automatic fail_to(input logic [3:0] t);
    submit(16'h9999, 1'b1, mk(0, 0, 1, t, (t == 4'd5), (t == 4'd5) ? 7'd3 : 7'd0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    pin_in = 17'd0;
    m_pin  = {1'b1, 16'h0000};
    p1     = {1'b1, 16'h1234};
    p2     = {1'b0, 16'h5678};
    p3     = {1'b0, 16'h0000};
    p4     = {1'b0, 16'h0000};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_reset", 32'(snap()), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("after_reset", 32'(snap()), 32'd0);

    // User PIN accepted
    submit(16'h1234, 1'b1, mk(1, 0, 0, 4'd0, 0, 7'd0));

    // Five failures lead to lockout, then countdown 3->0 over 12 cycles
    for (int i = 1; i <= 5; i++) fail_to(4'(i));
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("tempo_k%0d", k), 32'(tempo_restante), 32'(3 - k / 4));
      chk($sformatf("bloq_k%0d", k), 32'(bloqueado), (k < 12) ? 32'd1 : 32'd0);
      chk($sformatf("tent_k%0d", k), 32'(tentativas), (k < 12) ? 32'd5 : 32'd0);
    end

    // Lockout: user PIN ignored, master PIN releases
    for (int i = 1; i <= 5; i++) fail_to(4'(i));
    submit(16'h1234, 1'b0, mk(0, 0, 0, 4'd0, 0, 7'd0));
    repeat (2) @(negedge clk);
    chk("lock_ignore_tent", 32'(tentativas), 32'd5);
    chk("lock_ignore_bloq", 32'(bloqueado), 32'd1);
    submit(16'h0000, 1'b1, mk(0, 1, 0, 4'd0, 0, 7'd0));
    @(negedge clk);
    chk("after_master", 32'(snap()), 32'd0);

    // Disabled PIN and blank digits never match
    submit(16'h5678, 1'b1, mk(0, 0, 1, 4'd1, 0, 7'd0));
    m_pin = {1'b1, 16'hEEEE};
    submit(16'hEEEE, 1'b1, mk(0, 0, 1, 4'd2, 0, 7'd0));
    m_pin = {1'b1, 16'h0000};

    // Reset after two fails, then reset mid-lockout
    do_reset();
    submit(16'h1234, 1'b1, mk(1, 0, 0, 4'd0, 0, 7'd0));
    for (int i = 1; i <= 5; i++) fail_to(4'(i));
    @(negedge clk);
    do_reset();
    submit(16'h1234, 1'b1, mk(1, 0, 0, 4'd0, 0, 7'd0));
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/verificar_senha.md
Name: verificar_senha

Overview:
- Consumer end of the PIN-entry interface. Watches the `pinPac_t` word produced by the keypad PIN assembler and detects each submission on the rising edge of `status`.
- Compares the submitted PIN against the master PIN and the four user PINs held in `setupPac_t`, then issues one-cycle result pulses.
- Counts consecutive failures and enforces a timed lockout.
- Sits between the PIN assembler and the door-lock operational FSM, on the divided (~1 kHz) system clock.

Parameters:
- MAX_TENTATIVAS, 5, consecutive failures that trigger lockout (1..15).
- BLOQUEIO_SEG, 30, lockout duration in seconds (1..127).
- TICKS_PER_SEC, 1000, `clk` cycles per second (≥1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- pin_in  in  17 (pinPac_t)  submitted PIN; `status` high marks a submission, digit value 4'hE means blank.
- data_setup  in  100 (setupPac_t)  configured PINs; only `master_pin`/`pin1..pin4` are used, each valid only when its `status`=1.
- senha_ok  out  1  one-cycle pulse, user PIN matched.
- master_ok  out  1  one-cycle pulse, master PIN matched.
- senha_fail  out  1  one-cycle pulse, no match.
- bloqueado  out  1  level, lockout active.
- tentativas  out  4  consecutive failure count.
- tempo_restante  out  7  lockout seconds remaining; 0 when not locked.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - All outputs go to 0, the tick counter clears, `status_prev` clears, and state becomes IDLE.
  - Reset has priority in every state, including mid-lockout and mid-compare.
- Submission detect:
  - Register `status_prev` every cycle.
  - A submission is `pin_in.status`=1 && `status_prev`=0. The upstream assembler holds `status` high for 2 cycles; each submission must be counted exactly once.
- States: IDLE, COMPARA, BLOQUEADO.
- IDLE:
  - On submission at edge E0: latch the 16 digits into `pin_reg` and go to COMPARA.
- COMPARA (edge E1): evaluate and register the result, so the pulse is high from E1 to E2 and latency is 1 cycle after capture.
  - A stored PIN matches iff its `status`=1, all 4 digits are equal to `pin_reg`, and `pin_reg` contains no 4'hE digit.
  - Master match has priority: `master_ok`=1, `tentativas`←0, go to IDLE. Do not also assert `senha_ok`.
  - Else any enabled user pin1..pin4 matches: `senha_ok`=1, `tentativas`←0, go to IDLE.
  - Else: `senha_fail`=1 and `tentativas`←`tentativas`+1.
    - If the new count equals MAX_TENTATIVAS: go to BLOQUEADO, `bloqueado`←1, `tempo_restante`←BLOQUEIO_SEG, tick←0.
    - Otherwise go to IDLE.
- BLOQUEADO:
  - Tick counter runs 0..TICKS_PER_SEC−1. On wrap, decrement `tempo_restante`.
  - When it decrements from 1 to 0: `bloqueado`←0, `tentativas`←0, go to IDLE in the same cycle.
  - A submission during lockout goes through the same capture/compare timing.
    - If it matches the master PIN: `master_ok` pulse, lockout ends immediately (`bloqueado`, `tempo_restante`, `tentativas`←0).
    - Any other submission is ignored: no pulse, counters unchanged, countdown keeps running through the compare cycle.
- A submission arriving while in COMPARA is not possible with the upstream 2-cycle status. If one occurs, it is dropped because `status_prev` is still 1.
- `data_setup` is sampled during COMPARA. Changes at any other time have no effect on an in-flight result.
- Pulse outputs are never high for more than one consecutive cycle. At most one of the three pulses is high in any cycle.
- `tentativas` saturates at MAX_TENTATIVAS and never wraps.

Test Plan:
1. pin1={1,1,2,3,4}, others disabled; drive `pin_in`={1,1,2,3,4} for 2 cycles → `senha_ok`=1 for exactly 1 cycle, 1 clock after the capture edge; `tentativas`=0; no second pulse.
2. MAX_TENTATIVAS=5; submit {9,9,9,9} five times → five `senha_fail` pulses and `tentativas` reads 1,2,3,4. The 5th gives `bloqueado`=1, `tempo_restante`=BLOQUEIO_SEG, `tentativas`=5.
3. TICKS_PER_SEC=4, BLOQUEIO_SEG=3, lockout entered → `tempo_restante` steps 3→2→1→0, one step every 4 cycles. `bloqueado` and `tentativas` reach 0 on the 12th cycle after entry.
4. During lockout, submit valid pin1 → no pulse and counters unchanged. Then submit master {1,0,0,0,0} → `master_ok` pulse, `bloqueado`=0, `tentativas`=0, `tempo_restante`=0.
5. pin2={0,5,6,7,8} (disabled), submit 5678 → `senha_fail`. Then set master={1,E,E,E,E} and submit {E,E,E,E} → `senha_fail`, not `master_ok`.
6. Two fails then `rst` high 1 cycle; also `rst` asserted mid-lockout → next edge all outputs 0, state IDLE, and a following correct PIN gives `senha_ok`.
